// File: rtl/reference_nco_if.sv
// Frequency request / tick inputs and reference sample outputs of reference_nco.
interface reference_nco_if #(
  parameter int W       = 13,
  parameter int PHASE_W = 32
);
  logic [W-1:0]       frequency_in;
  logic               sample_tick;
  logic               ref_valid;
  logic signed [15:0] ref_i;
  logic signed [15:0] ref_q;
  logic [PHASE_W-1:0] phase_out;
  logic [W-1:0]       freq_applied;
  logic               freq_pending;

  modport master (
    output frequency_in, sample_tick,
    input  ref_valid, ref_i, ref_q, phase_out, freq_applied, freq_pending
  );

  modport slave (
    input  frequency_in, sample_tick,
    output ref_valid, ref_i, ref_q, phase_out, freq_applied, freq_pending
  );
endinterface

// File: rtl/reference_nco.sv
// Phase-continuous reference NCO producing sine/cosine (or square) I/Q samples per audio tick.
// Define REFERENCE_NCO_LUT_EN for a quarter-wave sine ROM; otherwise square-wave outputs.
module reference_nco #(
  parameter int W               = 13,
  parameter int FREQUENCY_RANGE = 8192,
  parameter int PHASE_W         = 32,
  parameter int INC_MULT        = 89478
) (
  input  logic            clk,
  input  logic            reset_active,
  reference_nco_if.slave  bus
);

  localparam logic [31:0] F_MAX = 32'(FREQUENCY_RANGE - 1);
  localparam logic [PHASE_W-1:0] QUARTER = PHASE_W'(1) << (PHASE_W - 2);

`ifdef REFERENCE_NCO_LUT_EN
  function automatic logic [256*15-1:0] build_rom();
    logic [256*15-1:0] rom;
    real x, term, s;
    int  v;
    rom = '0;
    for (int k = 0; k < 256; k++) begin
      x    = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 256.0;
      term = x;
      s    = x;
      for (int n = 1; n < 12; n++) begin
        term = -term * x * x / real'((2 * n) * (2 * n + 1));
        s    = s + term;
      end
      v = $rtoi(32767.0 * s + 0.5);
      rom[k*15 +: 15] = 15'(v);
    end
    return rom;
  endfunction

  localparam logic [256*15-1:0] SIN_ROM = build_rom();

  // top[8] is the odd-quadrant flag that mirrors the ROM index
  function automatic logic [14:0] rom_mag(input logic [8:0] top);
    logic [7:0] idx;
    idx = top[8] ? ~top[7:0] : top[7:0];
    return SIN_ROM[int'(idx)*15 +: 15];
  endfunction
`endif

  function automatic logic signed [15:0] apply_sign(input logic neg, input logic [14:0] mag);
    logic signed [15:0] m;
    m = $signed({1'b0, mag});
    return neg ? -m : m;
  endfunction

  logic [W-1:0]       target;
  logic [PHASE_W:0]   sum;
  logic               apply_new;
  logic [W-1:0]       fa_next;
  logic [PHASE_W-1:0] inc_next;
  logic [PHASE_W-1:0] cos_ph;

  logic [PHASE_W-1:0] acc_p0;
  logic [PHASE_W-1:0] inc_p0;
  logic [W-1:0]       freq_applied_p0;
  logic               freq_pending_p0;
  logic               vld_p0;

  logic [PHASE_W-1:0] phase_p1;
  logic [14:0]        mag_i_p1;
  logic [14:0]        mag_q_p1;
  logic               neg_i_p1;
  logic               neg_q_p1;
  logic               vld_p1;

  always_comb begin
    target = bus.frequency_in;
    if (32'(bus.frequency_in) > F_MAX) target = W'(F_MAX);
    sum       = {1'b0, acc_p0} + {1'b0, inc_p0};
    // a zero frequency has no carry to wait for, so the request is taken at once
    apply_new = bus.sample_tick && (sum[PHASE_W] || (freq_applied_p0 == '0));
    fa_next   = apply_new ? target : freq_applied_p0;
    inc_next  = PHASE_W'(fa_next) * PHASE_W'(INC_MULT);
    cos_ph    = acc_p0 + QUARTER;
  end

  // Stage p0: accumulator and frequency bookkeeping
  always_ff @(posedge clk) begin
    if (reset_active) begin
      acc_p0          <= '0;
      inc_p0          <= '0;
      freq_applied_p0 <= '0;
      freq_pending_p0 <= 1'b0;
      vld_p0          <= 1'b0;
    end else begin
      vld_p0          <= bus.sample_tick;
      freq_pending_p0 <= (target != fa_next);
      if (bus.sample_tick) begin
        acc_p0          <= sum[PHASE_W-1:0];
        inc_p0          <= inc_next;
        freq_applied_p0 <= fa_next;
      end
    end
  end

  // Stage p1: quadrant decode and magnitude lookup
  always_ff @(posedge clk) begin
    if (reset_active) vld_p1 <= 1'b0;
    else              vld_p1 <= vld_p0;
    phase_p1 <= acc_p0;
    neg_i_p1 <= acc_p0[PHASE_W-1];
    neg_q_p1 <= cos_ph[PHASE_W-1];
`ifdef REFERENCE_NCO_LUT_EN
    mag_i_p1 <= rom_mag(acc_p0[PHASE_W-2:PHASE_W-10]);
    mag_q_p1 <= rom_mag(cos_ph[PHASE_W-2:PHASE_W-10]);
`else
    mag_i_p1 <= 15'h7fff;
    mag_q_p1 <= 15'h7fff;
`endif
  end

  // Stage p2: registered outputs, held between strobes
  always_ff @(posedge clk) begin
    if (reset_active) begin
      bus.ref_valid <= 1'b0;
      bus.ref_i     <= '0;
      bus.ref_q     <= '0;
      bus.phase_out <= '0;
    end else begin
      bus.ref_valid <= vld_p1;
      if (vld_p1) begin
        bus.ref_i     <= apply_sign(neg_i_p1, mag_i_p1);
        bus.ref_q     <= apply_sign(neg_q_p1, mag_q_p1);
        bus.phase_out <= phase_p1;
      end
    end
  end

  assign bus.freq_applied = freq_applied_p0;
  assign bus.freq_pending = freq_pending_p0;

endmodule

// File: tb/tb_reference_nco.sv
// Directed bench for reference_nco with a queue-based reference model checked every cycle.
module tb_reference_nco;

  localparam int  TW   = 14;
  localparam int  TFR  = 16384;
  localparam longint INC = 89478;
  localparam longint TWO32 = 64'h1_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reference_nco_if #(.W(TW), .PHASE_W(32)) bus ();
  reference_nco_if #(.W(13), .PHASE_W(32)) bus2 ();

  reference_nco #(.W(TW), .FREQUENCY_RANGE(TFR), .PHASE_W(32), .INC_MULT(89478)) dut (
    .clk(clk), .reset_active(rst), .bus(bus)
  );

  reference_nco #(.W(13), .FREQUENCY_RANGE(5000), .PHASE_W(32), .INC_MULT(89478)) dut_clamp (
    .clk(clk), .reset_active(rst), .bus(bus2)
  );

  assign bus2.sample_tick = bus.sample_tick;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected sample value from the top 10 phase bits (midpoint of each ROM cell)
  function automatic int exp_i(input longint ph);
`ifdef REFERENCE_NCO_LUT_EN
    real a, r;
    a = 2.0 * 3.14159265358979323846 * (real'(ph >> 22) + 0.5) / 1024.0;
    r = 32767.0 * $sin(a);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
`else
    return (ph < TWO32 / 2) ? 32767 : -32767;
`endif
  endfunction

  function automatic int exp_q(input longint ph);
    return exp_i((ph + TWO32 / 4) % TWO32);
  endfunction

  longint m_acc, m_fa, m_ph, tgt, s, ecount;
  int     m_i, m_q;
  bit     m_vld, m_pend;
  longint q_due[$];
  longint q_ph[$];

  always @(posedge clk) begin
    ecount++;
    if (rst) begin
      m_acc = 0; m_fa = 0; m_pend = 0; m_vld = 0;
      m_ph = 0; m_i = 0; m_q = 0;
      q_due.delete(); q_ph.delete();
    end else begin
      tgt = longint'(bus.frequency_in);
      if (tgt > TFR - 1) tgt = TFR - 1;
      m_vld = 0;
      if (q_due.size() > 0 && q_due[0] == ecount) begin
        void'(q_due.pop_front());
        m_ph  = q_ph.pop_front();
        m_vld = 1;
        m_i   = exp_i(m_ph);
        m_q   = exp_q(m_ph);
      end
      if (bus.sample_tick) begin
        s = m_acc + m_fa * INC;
        m_acc = s % TWO32;
        if (s >= TWO32 || m_fa == 0) m_fa = tgt;
        q_due.push_back(ecount + 2);
        q_ph.push_back(m_acc);
      end
      m_pend = (tgt != m_fa);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("ref_valid",    longint'(bus.ref_valid),    longint'(m_vld));
      chk("freq_pending", longint'(bus.freq_pending), longint'(m_pend));
      chk("freq_applied", longint'(bus.freq_applied), m_fa);
      chk("phase_out",    longint'(bus.phase_out),    m_ph);
      chk("ref_i",        longint'(bus.ref_i),        longint'(m_i));
      chk("ref_q",        longint'(bus.ref_q),        longint'(m_q));
    end
  end

  task automatic tick_gap(input int gap);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  int si[5];
  int sq[5];

  initial begin
    rst = 1'b1;
    bus.frequency_in  = '0;
    bus.sample_tick   = 1'b0;
    bus2.frequency_in = 13'd6000;
    ecount = 0;
    @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid",   longint'(bus.ref_valid), 0);
    chk("rst_phase",   longint'(bus.phase_out), 0);
    chk("rst_i",       longint'(bus.ref_i), 0);
    chk("rst_pending", longint'(bus.freq_pending), 0);
    chk("rst_fa",      longint'(bus.freq_applied), 0);

    rst = 1'b0;
    bus.frequency_in = 14'd1000;
    @(negedge clk);
    chk("pending_after_rst", longint'(bus.freq_pending), 1);
    repeat (4) @(negedge clk);

    // first tick: zero-frequency exception, phase stays 0
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    chk("fa_first_tick", longint'(bus.freq_applied), 1000);
    @(negedge clk);
    chk("valid_early", longint'(bus.ref_valid), 0);
    @(negedge clk);
    chk("valid_lat3", longint'(bus.ref_valid), 1);
    chk("first_phase", longint'(bus.phase_out), 0);
`ifdef REFERENCE_NCO_LUT_EN
    chk("first_i", longint'(bus.ref_i), 101);
    chk("first_q", longint'(bus.ref_q), 32767);
`else
    chk("first_i", longint'(bus.ref_i), 32767);
    chk("first_q", longint'(bus.ref_q), 32767);
`endif
    repeat (17) @(negedge clk);
    tick_gap(20);
    chk("phase_step1", longint'(bus.phase_out), 89478000);
    tick_gap(20);
    chk("phase_step2", longint'(bus.phase_out), 178956000);

    // frequency change waits for the carry tick
    bus.frequency_in = 14'd2000;
    @(negedge clk);
    chk("pending_2000", longint'(bus.freq_pending), 1);
    chk("fa_hold_1000", longint'(bus.freq_applied), 1000);
    for (int t = 0; t < 60 && bus.freq_applied != 14'd2000; t++) tick_gap(20);
    chk("switch_to_2000", longint'(bus.freq_applied), 2000);
    chk("pending_clear", longint'(bus.freq_pending), 0);

    repeat (5) tick_gap(1);
    repeat (4) @(negedge clk);

    // last-wins: returning to the applied frequency clears pending
    bus.frequency_in = 14'd3000;
    @(negedge clk);
    chk("pending_3000", longint'(bus.freq_pending), 1);
    bus.frequency_in = 14'd2000;
    @(negedge clk);
    chk("pending_back", longint'(bus.freq_pending), 0);

    // reset one cycle after a tick drops that sample
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid", longint'(bus.ref_valid), 0);
    chk("rst_mid_phase", longint'(bus.phase_out), 0);
    chk("rst_mid_i",     longint'(bus.ref_i), 0);
    chk("rst_mid_fa",    longint'(bus.freq_applied), 0);
    @(negedge clk);
    chk("rst_mid_valid2", longint'(bus.ref_valid), 0);

    // tick coincident with reset is ignored
    rst = 1'b1;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.sample_tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_tick_fa", longint'(bus.freq_applied), 0);

    // 12000 Hz steps just under a quarter turn per tick
    bus.frequency_in = 14'd12000;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      tick_gap(6);
      si[k] = int'(bus.ref_i);
      sq[k] = int'(bus.ref_q);
    end
    chk("fa_12000", longint'(bus.freq_applied), 12000);
`ifndef REFERENCE_NCO_LUT_EN
    chk("sq1_i", si[1],  32767); chk("sq1_q", sq[1],  32767);
    chk("sq2_i", si[2],  32767); chk("sq2_q", sq[2], -32767);
    chk("sq3_i", si[3], -32767); chk("sq3_q", sq[3], -32767);
    chk("sq4_i", si[4], -32767); chk("sq4_q", sq[4],  32767);
`endif

    chk("clamp_fa",      longint'(bus2.freq_applied), 4999);
    chk("clamp_pending", longint'(bus2.freq_pending), 0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reference_nco.md
REFERENCE_NCO -- requirements
Module: reference_nco

Interface
REQ-001 Parameter W, default 13, width of frequency_in and freq_applied in Hz.
REQ-002 Parameter FREQUENCY_RANGE, default 8192, exclusive upper bound of accepted frequency.
REQ-003 Parameter PHASE_W, default 32, phase accumulator width.
REQ-004 Parameter INC_MULT, default 89478, phase increment per Hz (round(2^32/48000)).
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 reset_active  input  1  synchronous, active-high reset.
REQ-007 frequency_in  input  W  requested reference frequency, unsigned Hz, from frequency controller.
REQ-008 sample_tick  input  1  one-cycle strobe per audio sample (48 kHz nominal).
REQ-009 ref_valid  output  1  one-cycle strobe, ref_i/ref_q updated.
REQ-010 ref_i  output  16  signed in-phase reference (sine).
REQ-011 ref_q  output  16  signed quadrature reference (cosine).
REQ-012 phase_out  output  PHASE_W  accumulator value used for current ref sample.
REQ-013 freq_applied  output  W  frequency currently driving the accumulator.
REQ-014 freq_pending  output  1  high while a requested frequency awaits application.

Function
REQ-015 Target = min(frequency_in, FREQUENCY_RANGE-1), evaluated every clock.
REQ-016 freq_pending SHALL be 1 exactly when target != freq_applied, registered one cycle after frequency_in changes.
REQ-017 Last-wins: a change while pending replaces target; returning to freq_applied clears freq_pending.
REQ-018 On sample_tick: acc <= acc + inc, modulo 2^PHASE_W; inc = freq_applied*INC_MULT, PHASE_W bits, no overflow for defaults.
REQ-019 Frequency update applied only on a sample_tick whose addition carries out of bit PHASE_W-1 (phase continuity), new inc effective from the following tick.
REQ-020 Exception: if freq_applied==0, pending target applied on next sample_tick; acc stays 0 on that tick.
REQ-021 sample_tick with no pending change and no carry: freq_applied unchanged.
REQ-022 Pipeline: tick at cycle N -> acc registered N+1 -> lookup N+2 -> ref_i/ref_q/phase_out registered and ref_valid=1 at N+3 for exactly one cycle.
REQ-023 Quadrant = phase[PHASE_W-1:PHASE_W-2]; cosine uses phase + 2^(PHASE_W-2).
REQ-024 sample_tick on consecutive cycles SHALL be accepted, one ref_valid per tick, in order.
REQ-025 ref_i/ref_q/phase_out hold value between ref_valid strobes.

Reset
REQ-026 reset_active high at a clock edge: acc, inc, freq_applied, phase_out, ref_i, ref_q = 0; ref_valid, freq_pending = 0.
REQ-027 Reset mid-operation discards all in-flight pipeline stages; no ref_valid for ticks preceding reset.
REQ-028 sample_tick coincident with reset_active ignored.
REQ-029 First cycle after reset: freq_pending reflects target != 0.

Configuration
REQ-030 Macro REFERENCE_NCO_LUT_EN defined: 256-entry quarter-wave sine ROM, entry k = round(32767*sin(pi/2*(k+0.5)/256)), index phase[PHASE_W-3:PHASE_W-10], mirrored index in quadrants 1/3, negated in quadrants 2/3.
REQ-031 Macro undefined: square outputs, ref_i = +32767 in quadrants 0-1 else -32767, ref_q = +32767 in quadrants 0,3 else -32767; no ROM instantiated.
REQ-032 Latency (REQ-022) identical in both builds.

Verification
REQ-033 Reset 2 cycles with frequency_in=0 -> all outputs 0, freq_pending=0, no ref_valid.
REQ-034 frequency_in=1000, ticks every 20 cycles -> freq_applied=1000 after first tick, phase_out steps 89478000 per tick, ref_valid 3 cycles after each tick; LUT build first sample ref_i=101, ref_q=32767.
REQ-035 Change 1000->2000 mid-cycle -> freq_pending=1, freq_applied stays 1000 until carry tick, then 2000, pending=0, phase_out continuous across switch.
REQ-036 FREQUENCY_RANGE=5000, frequency_in=6000 -> freq_applied=4999.
REQ-037 Square build, freq 12000 -> ref_i/ref_q sequence (+,+),(+,-),(-,-),(-,+) per 4 ticks.
REQ-038 Reset asserted one cycle after a tick -> no ref_valid for that tick, all outputs 0 next cycle.
